// File: rtl/vga_frame_sequencer.sv
// Frame-rate sequencer: advances the scroll offset and pattern preset once per frame,
// with pause/run control and per-frame debounced buttons.
module vga_frame_sequencer #(
  parameter int unsigned HOLD_FRAMES     = 256,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       btn_next,
  input  logic       btn_pause,
  input  logic       auto_en,
  input  logic [2:0] speed,
  input  logic       dir,
  output logic [9:0] offset,
  output logic [1:0] preset,
  output logic       paused,
  output logic       frame_tick
);

  localparam logic [9:0] HoldLast = 10'(HOLD_FRAMES - 1);
  localparam logic [2:0] DebMax   = 3'(DEBOUNCE_FRAMES);

  typedef enum logic [0:0] {StRun, StPause} state_e;

  state_e     state_q, state_d;
  logic       vsync_q, vs_q;
  logic       tick, tick_q;
  logic [9:0] offset_q, offset_d;
  logic [1:0] preset_q, preset_d;
  logic [9:0] hold_q, hold_d;
  logic [2:0] nxt_cnt_q, nxt_cnt_d;
  logic [2:0] pse_cnt_q, pse_cnt_d;
  logic       nxt_press, pse_press, expire;

  // vsync is registered once, so the frame update lands one edge after it is sampled high.
  assign tick = vsync_q & ~vs_q;

  always_comb begin
    nxt_cnt_d = nxt_cnt_q;
    pse_cnt_d = pse_cnt_q;
    nxt_press = 1'b0;
    pse_press = 1'b0;
    if (tick) begin
      if (btn_next) begin
        if (nxt_cnt_q != DebMax) begin
          nxt_cnt_d = nxt_cnt_q + 3'd1;
          nxt_press = (nxt_cnt_q + 3'd1) == DebMax;
        end
      end else begin
        nxt_cnt_d = 3'd0;
      end
      if (btn_pause) begin
        if (pse_cnt_q != DebMax) begin
          pse_cnt_d = pse_cnt_q + 3'd1;
          pse_press = (pse_cnt_q + 3'd1) == DebMax;
        end
      end else begin
        pse_cnt_d = 3'd0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick && pse_press) begin
      unique case (state_q)
        StRun:   state_d = StPause;
        StPause: state_d = StRun;
        default: state_d = StRun;
      endcase
    end
  end

  // Offset step and hold count use the pre-toggle state on the tick.
  always_comb begin
    offset_d = offset_q;
    hold_d   = hold_q;
    preset_d = preset_q;
    expire   = 1'b0;
    if (tick && state_q == StRun) begin
      offset_d = dir ? offset_q - {7'd0, speed} : offset_q + {7'd0, speed};
      if (auto_en) begin
        if (hold_q == HoldLast) begin
          hold_d = 10'd0;
          expire = 1'b1;
        end else begin
          hold_d = hold_q + 10'd1;
        end
      end
    end
    if (nxt_press) begin
      hold_d = 10'd0;
    end
    if (expire || nxt_press) begin
      preset_d = preset_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q   <= 1'b1;
      vs_q      <= 1'b1;
      tick_q    <= 1'b0;
      state_q   <= StRun;
      offset_q  <= 10'd0;
      preset_q  <= 2'd0;
      hold_q    <= 10'd0;
      nxt_cnt_q <= 3'd0;
      pse_cnt_q <= 3'd0;
    end else begin
      vsync_q   <= vsync;
      vs_q      <= vsync_q;
      tick_q    <= tick;
      state_q   <= state_d;
      offset_q  <= offset_d;
      preset_q  <= preset_d;
      hold_q    <= hold_d;
      nxt_cnt_q <= nxt_cnt_d;
      pse_cnt_q <= pse_cnt_d;
    end
  end

  assign offset     = offset_q;
  assign preset     = preset_q;
  assign paused     = (state_q == StPause);
  assign frame_tick = tick_q;

endmodule
